sq_frame_accum_32: RTL and testbench

//  Downstream consumer of the 32-bit (y+1)^2 square stage. Accepts square

---
 rtl/sq_frame_accum_32.sv | 129 ++++++++++++
 tb/tb_sq_frame_accum_32.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/sq_frame_accum_32.sv
// Sums 32-bit square results per frame over a valid/ready stream and holds {sum, count, ovf} until taken.
// Optional build macro SQ_FRAME_ACCUM_SAT_EN: clamp the accumulator to all-ones on carry instead of wrapping.
module sq_frame_accum_32 #(
  parameter int ACC_W = 40,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      in_data_i,
  input  logic             in_valid_i,
  input  logic             in_last_i,
  output logic             in_ready_o,
  output logic [ACC_W-1:0] sum_out_o,
  output logic [CNT_W-1:0] cnt_out_o,
  output logic             ovf_out_o,
  output logic             out_valid_o,
  input  logic             out_ready_i
);

  typedef enum logic [0:0] {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_q, ovf_d;
  logic [ACC_W-1:0] sum_q, sum_d;
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;
  logic             ovf_out_q, ovf_out_d;

  logic             beat_s;
  logic [ACC_W:0]   sum_ext_s;
  logic             carry_s;
  logic [ACC_W-1:0] acc_upd_s;
  logic [CNT_W-1:0] cnt_upd_s;
  logic             ovf_upd_s;

  // Post-update values of the running frame state for the beat on the input.
  always_comb begin
    beat_s    = in_valid_i && (state_q == ST_ACCUM);
    sum_ext_s = {1'b0, acc_q} + {{(ACC_W + 1 - 32){1'b0}}, in_data_i};
    carry_s   = sum_ext_s[ACC_W];
`ifdef SQ_FRAME_ACCUM_SAT_EN
    if (carry_s) begin
      acc_upd_s = {ACC_W{1'b1}};
    end else begin
      acc_upd_s = sum_ext_s[ACC_W-1:0];
    end
`else
    acc_upd_s = sum_ext_s[ACC_W-1:0];
`endif
    if (cnt_q == {CNT_W{1'b1}}) begin
      cnt_upd_s = cnt_q;
    end else begin
      cnt_upd_s = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
    ovf_upd_s = ovf_q | carry_s;
  end

  // Next-state logic: accumulate in ACCUM, present and hold the result in HOLD.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    sum_d     = sum_q;
    cnt_out_d = cnt_out_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      ST_ACCUM: begin
        if (beat_s && in_last_i) begin
          sum_d     = acc_upd_s;
          cnt_out_d = cnt_upd_s;
          ovf_out_d = ovf_upd_s;
          acc_d     = {ACC_W{1'b0}};
          cnt_d     = {CNT_W{1'b0}};
          ovf_d     = 1'b0;
          state_d   = ST_HOLD;
        end else if (beat_s) begin
          acc_d = acc_upd_s;
          cnt_d = cnt_upd_s;
          ovf_d = ovf_upd_s;
        end else begin
          state_d = ST_ACCUM;
        end
      end
      ST_HOLD: begin
        if (out_ready_i) begin
          state_d = ST_ACCUM;
        end else begin
          state_d = ST_HOLD;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_ACCUM;
      acc_q     <= {ACC_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
      ovf_q     <= 1'b0;
      sum_q     <= {ACC_W{1'b0}};
      cnt_out_q <= {CNT_W{1'b0}};
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      sum_q     <= sum_d;
      cnt_out_q <= cnt_out_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign in_ready_o  = (state_q == ST_ACCUM);
  assign out_valid_o = (state_q == ST_HOLD);
  assign sum_out_o   = sum_q;
  assign cnt_out_o   = cnt_out_q;
  assign ovf_out_o   = ovf_out_q;

endmodule

// File: tb/tb_sq_frame_accum_32.sv
// Scoreboard bench for sq_frame_accum_32 (ACC_W=33 to reach the carry, CNT_W=4 to reach count saturation).
module tb_sq_frame_accum_32;
  localparam int ACC_W = 33;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [ACC_W-1:0] sum;
    logic [CNT_W-1:0] cnt;
    logic             ovf;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic [31:0]      in_data = 32'd0;
  logic             in_valid = 1'b0;
  logic             in_last = 1'b0;
  logic             in_ready;
  logic [ACC_W-1:0] sum_out;
  logic [CNT_W-1:0] cnt_out;
  logic             ovf_out;
  logic             out_valid;
  logic             out_ready = 1'b1;

  int   checks = 0;
  int   failures = 0;
  res_t exp_q[$];

  sq_frame_accum_32 #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data_i(in_data), .in_valid_i(in_valid), .in_last_i(in_last), .in_ready_o(in_ready),
    .sum_out_o(sum_out), .cnt_out_o(cnt_out), .ovf_out_o(ovf_out),
    .out_valid_o(out_valid), .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Drive one beat and return #1 after the edge on which it was accepted.
  task automatic send(input logic [31:0] d, input logic l);
    int n;
    @(negedge clk);
    in_data = d; in_last = l; in_valid = 1'b1;
    for (n = 0; n < 100; n++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (n == 100) begin
      checks++; failures++;
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
    end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic push(input logic [ACC_W-1:0] s, input logic [CNT_W-1:0] c, input logic o);
    res_t r;
    r.sum = s; r.cnt = c; r.ovf = o;
    exp_q.push_back(r);
  endtask

  // Monitor: compare each result at the cycle it is handed off.
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_result actual=sum 0x%0h required=no_result", sum_out);
        end else begin
          e = exp_q.pop_front();
          chk("res_sum", 64'(sum_out), 64'(e.sum));
          chk("res_cnt", 64'(cnt_out), 64'(e.cnt));
          chk("res_ovf", 64'(ovf_out), 64'(e.ovf));
        end
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_cnt", 64'(cnt_out), 64'd0);
    chk("rst_ovf", 64'(ovf_out), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);

    // 1: back-to-back, latency 1
    push(33'd137, 4'd2, 1'b0);
    send(32'd121, 1'b0);
    send(32'd16, 1'b1);
    chk("t1_latency_valid", 64'(out_valid), 64'd1);
    @(posedge clk); #1;
    chk("t1_retain_sum", 64'(sum_out), 64'd137);
    chk("t1_back_accum", 64'(in_ready), 64'd1);

    // 2: downstream stalls for 5 cycles
    out_ready = 1'b0;
    push(33'd137, 4'd2, 1'b0);
    send(32'd121, 1'b0);
    send(32'd16, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid_held", 64'(out_valid), 64'd1);
      chk("t2_in_ready_low", 64'(in_ready), 64'd0);
      chk("t2_sum_stable", 64'(sum_out), 64'd137);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("t2_accum_after", 64'(in_ready), 64'd1);
    chk("t2_valid_clear", 64'(out_valid), 64'd0);

    // 3: single max beat
    push(33'h0FFFFFFFF, 4'd1, 1'b0);
    send(32'hFFFFFFFF, 1'b1);

    // 4: carry out of ACC_W
`ifdef SQ_FRAME_ACCUM_SAT_EN
    push(33'h1FFFFFFFF, 4'd3, 1'b1);
`else
    push(33'h0FFFFFFFD, 4'd3, 1'b1);
`endif
    send(32'hFFFFFFFF, 1'b0);
    send(32'hFFFFFFFF, 1'b0);
    send(32'hFFFFFFFF, 1'b1);

    // 5: reset mid-frame discards partial frame
    send(32'd121, 1'b0);
    send(32'd16, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_valid_in_reset", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push(33'd4, 4'd1, 1'b0);
    send(32'd4, 1'b1);

    // 6: gaps inside a frame, then a fresh frame
    push(33'd121, 4'd2, 1'b0);
    send(32'd100, 1'b0);
    repeat (3) @(negedge clk);
    send(32'd21, 1'b1);
    push(33'd9, 4'd1, 1'b0);
    send(32'd9, 1'b1);

    // count saturates at 2^CNT_W-1
    push(33'd17, 4'd15, 1'b0);
    for (int i = 0; i < 16; i++) send(32'd1, 1'b0);
    send(32'd1, 1'b1);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      checks++; failures++;
      $display("FAIL drain_timeout actual=%0d_pending required=0", exp_q.size());
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
